cpu_core: RTL

Parametrised multi-cycle successor to the single-cycle 16-bit CPU top. It fetches 16-bit instructions over a req/ack instruction-memory handshake, so memory may insert wait states. It executes one instruction per EXEC cycle against an internal register file and issues single-cycle stores on a data-write port. The datapath width and PC width are parametrised, and the core has explicit reset, halt and retire signalling.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/cpu_alu.sv | 39 +++
 rtl/cpu_core.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the multi-cycle cpu_core.
//   - opcode constants (instr[15:13]) and R-type func codes (instr[3:0])
//   - FSM state enum
//   - instruction field bit positions
package cpu_pkg;

    // Opcodes
    localparam logic [2:0] OP_RTYPE = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_BEQ   = 3'b010;
    localparam logic [2:0] OP_JMP   = 3'b011;
    localparam logic [2:0] OP_SW    = 3'b100;
    localparam logic [2:0] OP_BNE   = 3'b101;
    localparam logic [2:0] OP_NOP   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    // R-type function codes; 8..15 are NOPs
    localparam logic [3:0] FN_ADD = 4'd0;
    localparam logic [3:0] FN_SUB = 4'd1;
    localparam logic [3:0] FN_AND = 4'd2;
    localparam logic [3:0] FN_OR  = 4'd3;
    localparam logic [3:0] FN_XOR = 4'd4;
    localparam logic [3:0] FN_SHL = 4'd5;
    localparam logic [3:0] FN_SHR = 4'd6;
    localparam logic [3:0] FN_SLT = 4'd7;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    // Instruction field positions
    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 13;
    localparam int unsigned RD_LSB   = 10;
    localparam int unsigned RS_LSB   = 7;
    localparam int unsigned RT_LSB   = 4;
    localparam int unsigned REG_AW   = 3;
    localparam int unsigned FUNC_W   = 4;
    localparam int unsigned IMM_W    = 7;
    localparam int unsigned JMP_W    = 13;
    localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for cpu_core.
//   a, b    in  DATA_W  operands
//   func    in  4       function code (FN_ADD..FN_SLT; 8..15 give result 0)
//   result  out DATA_W  result, modulo 2^DATA_W
//   carry   out 1       add: carry-out; sub: no-borrow; others 0
//   zero    out 1       result == 0
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        func,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        unique case (func)
            FN_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            // a + ~b + 1: carry set means no borrow
            FN_SUB: {carry, result} = {1'b0, a} + {1'b0, ~b} + (DATA_W + 1)'(1);
            FN_AND: result = a & b;
            FN_OR:  result = a | b;
            FN_XOR: result = a ^ b;
            FN_SHL: result = {a[DATA_W-2:0], 1'b0};
            FN_SHR: result = {1'b0, a[DATA_W-1:1]};
            FN_SLT: result = DATA_W'($signed(a) < $signed(b));
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 16-bit-instruction CPU (FETCH -> EXEC, HALT terminal).
//   clk, rst            clock; asynchronous active-high reset
//   imem_req/addr/ack/rdata  instruction fetch handshake (addr = pc, held while waiting)
//   dmem_we/addr/wdata  single-cycle store port, valid only in EXEC
//   pc                  current program counter
//   retire              high during each EXEC cycle
//   halted              core is in HALT (left only by reset)
//   carry, zero         flags from the last R-type or ADDI
//   dbg_sel/dbg_data    combinational register file read port
// Build option: define CPU_CORE_BNE_EN to make opcode 101 a BNE; otherwise it is a NOP.
module cpu_core
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_rdata,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [PC_W-1:0]   pc,
    output logic              retire,
    output logic              halted,
    output logic              carry,
    output logic              zero,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];
    logic                carry_q, zero_q;
    // Low through reset and for the first cycle after, so imem_req rises one cycle after release
    logic                req_en_q;

    // Decoded fields
    logic [2:0]          opcode;
    logic [REG_AW-1:0]   rd, rs, rt;
    logic [FUNC_W-1:0]   func;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   imm_d;
    logic [PC_W-1:0]     br_target, jmp_target;
    logic [DATA_W-1:0]   rd_val, rs_val, rt_val;

    // ALU interface
    logic [DATA_W-1:0]   alu_b, alu_result;
    logic [3:0]          alu_func;
    logic                alu_carry, alu_zero;

    logic                rf_we, flags_we;

    assign opcode     = ir_q[OPC_MSB:OPC_LSB];
    assign rd         = ir_q[RD_LSB +: REG_AW];
    assign rs         = ir_q[RS_LSB +: REG_AW];
    assign rt         = ir_q[RT_LSB +: REG_AW];
    assign func       = ir_q[FUNC_W-1:0];
    assign imm        = ir_q[IMM_W-1:0];
    assign imm_d      = DATA_W'($signed(imm));
    assign br_target  = pc_q + PC_W'(1) + PC_W'($signed(imm));
    assign jmp_target = PC_W'(ir_q[JMP_W-1:0]);

    assign rd_val = (rd == '0) ? '0 : rf_q[rd];
    assign rs_val = (rs == '0) ? '0 : rf_q[rs];
    assign rt_val = (rt == '0) ? '0 : rf_q[rt];

    assign alu_func = (opcode == OP_ADDI) ? FN_ADD : func;
    assign alu_b    = (opcode == OP_ADDI) ? imm_d : rt_val;

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .func   (alu_func),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        rf_we    = 1'b0;
        flags_we = 1'b0;
        dmem_we  = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                if (req_en_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_FETCH;
                case (opcode)
                    OP_RTYPE: begin
                        if (!func[3]) begin
                            rf_we    = (rd != '0);
                            flags_we = 1'b1;
                        end
                    end
                    OP_ADDI: begin
                        rf_we    = (rd != '0);
                        flags_we = 1'b1;
                    end
                    OP_BEQ: begin
                        if (rd_val == rs_val) pc_d = br_target;
                    end
`ifdef CPU_CORE_BNE_EN
                    OP_BNE: begin
                        if (rd_val != rs_val) pc_d = br_target;
                    end
`else
                    OP_BNE: ; // unused slot in this build: plain NOP
`endif
                    OP_JMP:  pc_d = jmp_target;
                    OP_SW:   dmem_we = 1'b1;
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            req_en_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_en_q <= 1'b1;
            if (flags_we) begin
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
            if (rf_we) begin
                rf_q[rd] <= alu_result;
            end
        end
    end

    assign imem_req   = (state_q == ST_FETCH) && req_en_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = rs_val + imm_d;
    assign dmem_wdata = rd_val;
    assign pc         = pc_q;
    assign retire     = (state_q == ST_EXEC);
    assign halted     = (state_q == ST_HALT);
    assign carry      = carry_q;
    assign zero       = zero_q;
    assign dbg_data   = (dbg_sel == '0) ? '0 : rf_q[dbg_sel];

endmodule
